// File: rtl/syn_fifo.sv
// Single-clock FIFO with M-1 usable entries and a registered read port.
// Full/empty come straight from the pointers; one slot stays empty to tell them apart.
module syn_fifo #(
    parameter int N = 8,
    parameter int M = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         write_en,
    input  logic         read_en,
    output logic [N-1:0] data_out,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(M);

    logic [N-1:0]  mem [M];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = ((wr_ptr + AW'(1)) == rd_ptr);
    assign do_wr = write_en && !full;
    assign do_rd = read_en && !empty;

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (reset && do_wr) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_syn_fifo.sv
// Directed bench for syn_fifo: reset, fill, drain, wrap, simultaneous
// access and mid-operation reset, all against hand-computed values.
module tb_syn_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       write_en;
    logic       read_en;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int passed = 0;
    int total  = 0;

    logic [7:0] vals [15];

    syn_fifo #(.N(8), .M(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .write_en (write_en),
        .read_en  (read_en),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        vals = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0d, 8'h8d, 8'h65, 8'h12,
                 8'h01, 8'h0d, 8'h76, 8'h3d, 8'hed, 8'h8c, 8'hf9};

        // Reset with random inputs
        reset    = 1'b0;
        data_in  = 8'($urandom);
        write_en = 1'($urandom);
        read_en  = 1'($urandom);
        tick();
        chk("rst_empty", 8'(empty), 8'd1);
        chk("rst_full", 8'(full), 8'd0);
        chk("rst_dout", data_out, 8'h00);
        reset    = 1'b1;
        write_en = 1'b0;
        read_en  = 1'b0;

        // Fill to capacity
        for (int i = 0; i < 15; i++) begin
            data_in  = vals[i];
            write_en = 1'b1;
            tick();
            chk($sformatf("fill_empty%0d", i), 8'(empty), 8'd0);
            chk($sformatf("fill_full%0d", i), 8'(full), (i == 14) ? 8'd1 : 8'd0);
        end
        data_in = 8'haa;
        tick();
        chk("fill_16th_full", 8'(full), 8'd1);
        write_en = 1'b0;

        // Drain in order
        for (int i = 0; i < 15; i++) begin
            read_en = 1'b1;
            tick();
            chk($sformatf("drain_dout%0d", i), data_out, vals[i]);
            chk($sformatf("drain_empty%0d", i), 8'(empty), (i == 14) ? 8'd1 : 8'd0);
            chk($sformatf("drain_full%0d", i), 8'(full), 8'd0);
        end
        tick();
        chk("drain_extra_dout", data_out, 8'hf9);
        chk("drain_extra_empty", 8'(empty), 8'd1);
        read_en = 1'b0;

        // Wrap: pointers start at 15
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 10; i++) begin
                data_in  = 8'(8'h30 + 8'(r * 16) + 8'(i));
                write_en = 1'b1;
                tick();
            end
            write_en = 1'b0;
            for (int i = 0; i < 10; i++) begin
                read_en = 1'b1;
                tick();
                chk($sformatf("wrap%0d_dout%0d", r, i), data_out,
                    8'(8'h30 + 8'(r * 16) + 8'(i)));
            end
            read_en = 1'b0;
            chk($sformatf("wrap%0d_empty", r), 8'(empty), 8'd1);
        end

        // Simultaneous read/write with 5 stored
        for (int i = 0; i < 5; i++) begin
            data_in  = 8'(8'h60 + 8'(i));
            write_en = 1'b1;
            tick();
        end
        read_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(8'h70 + 8'(i));
            tick();
            chk($sformatf("simul_dout%0d", i), data_out,
                (i < 5) ? 8'(8'h60 + 8'(i)) : 8'(8'h70 + 8'(i - 5)));
            chk($sformatf("simul_empty%0d", i), 8'(empty), 8'd0);
            chk($sformatf("simul_full%0d", i), 8'(full), 8'd0);
        end
        write_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("simul_rest%0d", i), data_out, 8'(8'h73 + 8'(i)));
        end
        chk("simul_occ_empty", 8'(empty), 8'd1);

        // Both requested while empty: only the write happens
        data_in  = 8'h99;
        write_en = 1'b1;
        read_en  = 1'b1;
        tick();
        chk("empty_both_empty", 8'(empty), 8'd0);
        chk("empty_both_dout", data_out, 8'h77);
        write_en = 1'b0;
        tick();
        chk("empty_both_read", data_out, 8'h99);
        chk("empty_both_after", 8'(empty), 8'd1);
        read_en = 1'b0;

        // Mid-operation reset with 7 stored
        for (int i = 0; i < 7; i++) begin
            data_in  = 8'(8'ha0 + 8'(i));
            write_en = 1'b1;
            tick();
        end
        reset    = 1'b0;
        read_en  = 1'b1;
        data_in  = 8'h55;
        tick();
        chk("midrst_empty", 8'(empty), 8'd1);
        chk("midrst_full", 8'(full), 8'd0);
        chk("midrst_dout", data_out, 8'h00);
        reset    = 1'b1;
        read_en  = 1'b0;
        data_in  = 8'hc3;
        write_en = 1'b1;
        tick();
        write_en = 1'b0;
        read_en  = 1'b1;
        tick();
        chk("midrst_new", data_out, 8'hc3);
        chk("midrst_new_empty", 8'(empty), 8'd1);
        tick();
        chk("midrst_hold", data_out, 8'hc3);
        read_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
